multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
Single-outstanding controller between the execute stage and the iterative multiplier and divider. It accepts one mul/div request, latches the operands, fires a one-cycle start pulse to the selected unit, and waits for that unit's ready. It then captures the result and exception, holds them for writeback until acknowledged, and stalls the pipeline while occupied. It also supports flush (cancel) and a watchdog timeout.

Parameters:
TIMEOUT, 40, max cycles in BUSY before a forced timeout (units need ≤34)
RSTATUS_REG, 30, destination register written on exception
MUL_EXC_CODE, 4, rstatus value for a mul exception
DIV_EXC_CODE, 5, rstatus value for a div exception

Ports:
clock  in  1  system clock; all logic is rising-edge
reset  in  1  synchronous, active-high
req_valid  in  1  execute stage presents a mul/div
req_op  in  1  0 = mul, 1 = div
req_a  in  32  operand A (multiplicand/dividend)
req_b  in  32  operand B (multiplier/divisor)
req_rd  in  5  destination register
req_ready  out  1  request accepted this cycle (high only in IDLE)
stall  out  1  freeze upstream stages
flush  in  1  cancel the in-flight operation
unit_a, unit_b  out  32 each  latched operands, stable from START until the next accept
ctrl_MULT  out  1  one-cycle multiplier start pulse
ctrl_DIV  out  1  one-cycle divider start pulse
mult_result, div_result  in  32 each  unit outputs
mult_exception, div_exception  in  1 each  unit overflow / divide-by-zero
mult_ready, div_ready  in  1 each  unit done
resp_valid  out  1  result is held for writeback
resp_data  out  32  result, or exception code
resp_rd  out  5  destination register, or RSTATUS_REG
resp_exception  out  1  the result is an exception
resp_ack  in  1  writeback consumed the response
timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- FSM has four states: IDLE, START, BUSY, DONE.
- Reset state: IDLE. All outputs are 0 except req_ready = 1. Latched registers are cleared to 0. Reset mid-operation aborts with no response.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch op, a, b, rd; go to START.
- START (exactly 1 cycle):
  - Pulse ctrl_MULT if op = 0, else ctrl_DIV.
  - Unit ready inputs are ignored this cycle, because a stale ready from the previous op may still be asserted.
  - Clear the cycle counter; go to BUSY.
- BUSY:
  - Counter increments every cycle.
  - The selected unit's ready high captures result and exception into the response registers; go to DONE.
  - The unselected unit's ready is ignored.
  - If counter = TIMEOUT-1 with no ready: pulse timeout, set resp_exception = 1, go to DONE.
- DONE:
  - resp_valid = 1; the response holds stable until resp_ack.
  - On resp_ack go to IDLE. There is no same-cycle re-accept: at least one idle bubble occurs between operations.
- Exception mapping:
  - resp_rd = RSTATUS_REG.
  - resp_data = MUL_EXC_CODE or DIV_EXC_CODE according to the latched op.
  - Otherwise resp_rd = latched rd and resp_data = unit result.
- stall = (state != IDLE) | (state == IDLE & req_valid).
  - Upstream holds its instruction in the accept cycle.
  - stall is released the cycle after resp_ack.
- Flush:
  - In START, BUSY or DONE, flush returns to IDLE next cycle. No resp_valid is produced and no timeout pulse is produced.
  - Flush wins over a same-cycle ready or resp_ack.
  - Flush in IDLE is ignored; a same-cycle req_valid is not accepted.
- Start pulse rules:
  - ctrl_MULT and ctrl_DIV are never both high.
  - Each is high for exactly one cycle per accepted request.
- Latency: accept at cycle t, start pulse at t+1, resp_valid at cycle r+1 where r is the first cycle after t+1 in which the selected unit's ready is high.
- resp_rd = 0 is passed through unchanged; suppressing the $r0 write is writeback's job.

Decomposition:
- Shared package (multdiv_pkg) holds:
  - the state encoding (2-bit);
  - the OP_MUL/OP_DIV constants;
  - the exception codes and RSTATUS_REG.
- One natural sub-module: multdiv_watchdog, a 6-bit counter with clear/enable and a terminal-count pulse. The FSM and response registers stay in the top module.

Test Plan:
- mul 7 × 6, rd = 5; mult_ready asserted 33 cycles after the pulse -> one ctrl_MULT pulse, resp_valid with data 42, rd 5, resp_exception 0; stall high throughout until the cycle after ack.
- div 100 / 0, rd = 9; div_exception = 1 with div_ready -> resp_rd 30, resp_data 5, resp_exception 1.
- mul 0x80000000 × 0xFFFFFFFF with mult_exception -> resp_rd 30, resp_data 4; no ctrl_DIV pulse ever.
- mult_ready held high continuously from a prior op, then new mul accepted -> ready ignored in START; response uses data sampled in BUSY, not earlier.
- flush asserted 10 cycles into a div -> IDLE next cycle, no resp_valid, req_ready = 1. A following mul 3 × 3 then returns 9.
- Unit never readies -> timeout pulse at BUSY cycle 40, resp_exception 1, resp_data 4 (mul). Also: resp_ack held low for 5 cycles -> response stable, stall high.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the mul/div sequencer: state encoding, op codes,
// exception codes and the status register index.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } mds_state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [4:0]  DEF_RSTATUS_REG  = 5'd30;
  localparam logic [31:0] DEF_MUL_EXC_CODE = 32'd4;
  localparam logic [31:0] DEF_DIV_EXC_CODE = 32'd5;

  localparam int          DEF_TIMEOUT      = 40;

endpackage

// File: rtl/multdiv_watchdog.sv
// Cycle counter for the BUSY phase; flags the last allowed cycle.
module multdiv_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [5:0] TC_VAL = 6'(TIMEOUT - 1);

  logic [5:0] r_cnt;

  // Clear has priority; otherwise count while enabled.
  always_ff @(posedge clock) begin
    if (reset)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 6'd1;
  end

  assign o_tc = i_en && (r_cnt == TC_VAL);

endmodule

// File: rtl/multdiv_sequencer.sv
// Single-outstanding controller between execute and the iterative
// multiplier/divider: accept, start pulse, wait, hold result for writeback.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int          TIMEOUT      = DEF_TIMEOUT,
  parameter logic [4:0]  RSTATUS_REG  = DEF_RSTATUS_REG,
  parameter logic [31:0] MUL_EXC_CODE = DEF_MUL_EXC_CODE,
  parameter logic [31:0] DIV_EXC_CODE = DEF_DIV_EXC_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  output logic        stall,
  input  logic        flush,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] mult_result,
  input  logic [31:0] div_result,
  input  logic        mult_exception,
  input  logic        div_exception,
  input  logic        mult_ready,
  input  logic        div_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_exception,
  input  logic        resp_ack,
  output logic        timeout
);

  mds_state_t  r_state, w_next;
  logic        r_op;
  logic [31:0] r_a, r_b;
  logic [4:0]  r_rd;
  logic [31:0] r_resp_data;
  logic [4:0]  r_resp_rd;
  logic        r_resp_exc;

  logic        w_accept, w_sel_ready, w_sel_exc, w_tc, w_capture, w_exc;
  logic [31:0] w_sel_res;

  // Only the unit that was started is listened to.
  assign w_sel_ready = (r_op == OP_DIV) ? div_ready      : mult_ready;
  assign w_sel_res   = (r_op == OP_DIV) ? div_result     : mult_result;
  assign w_sel_exc   = (r_op == OP_DIV) ? div_exception  : mult_exception;

  // Flush in IDLE blocks a same-cycle accept.
  assign w_accept  = (r_state == ST_IDLE) && req_valid && !flush;
  // Ready wins over a same-cycle watchdog expiry; flush wins over both.
  assign w_capture = (r_state == ST_BUSY) && !flush && (w_sel_ready || w_tc);
  assign w_exc     = w_sel_ready ? w_sel_exc : 1'b1;

  multdiv_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clock (clock),
    .reset (reset),
    .i_clr (r_state == ST_START),
    .i_en  (r_state == ST_BUSY),
    .o_tc  (w_tc)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)            w_next = ST_START;
      ST_START: w_next = flush ? ST_IDLE : ST_BUSY;
      ST_BUSY:  if (flush)               w_next = ST_IDLE;
                else if (w_capture)      w_next = ST_DONE;
      ST_DONE:  if (flush || resp_ack)   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Latch the request on accept; operands stay stable until the next accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op <= OP_MUL;
      r_a  <= '0;
      r_b  <= '0;
      r_rd <= '0;
    end else if (w_accept) begin
      r_op <= req_op;
      r_a  <= req_a;
      r_b  <= req_b;
      r_rd <= req_rd;
    end
  end

  // Capture the response, mapping exceptions onto the status register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_resp_data <= '0;
      r_resp_rd   <= '0;
      r_resp_exc  <= 1'b0;
    end else if (w_capture) begin
      r_resp_exc  <= w_exc;
      r_resp_rd   <= w_exc ? RSTATUS_REG : r_rd;
      r_resp_data <= w_exc ? ((r_op == OP_DIV) ? DIV_EXC_CODE : MUL_EXC_CODE)
                           : w_sel_res;
    end
  end

  assign req_ready      = (r_state == ST_IDLE);
  assign stall          = (r_state != ST_IDLE) || req_valid;
  assign unit_a         = r_a;
  assign unit_b         = r_b;
  assign ctrl_MULT      = (r_state == ST_START) && (r_op == OP_MUL);
  assign ctrl_DIV       = (r_state == ST_START) && (r_op == OP_DIV);
  assign resp_valid     = (r_state == ST_DONE);
  assign resp_data      = r_resp_data;
  assign resp_rd        = r_resp_rd;
  assign resp_exception = r_resp_exc;
  assign timeout        = (r_state == ST_BUSY) && !flush && !w_sel_ready && w_tc;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer; inputs driven and outputs
// checked on the falling edge.
module tb_multdiv_sequencer;

  logic        clock, reset;
  logic        req_valid, req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        req_ready, stall, flush;
  logic [31:0] unit_a, unit_b;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] mult_result, div_result;
  logic        mult_exception, div_exception, mult_ready, div_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_exception, resp_ack, timeout;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mul_cnt = 0, div_cnt = 0, both_cnt = 0, to_cnt = 0;

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .req_ready(req_ready),
    .stall(stall), .flush(flush), .unit_a(unit_a), .unit_b(unit_b),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .mult_result(mult_result),
    .div_result(div_result), .mult_exception(mult_exception),
    .div_exception(div_exception), .mult_ready(mult_ready), .div_ready(div_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_exception(resp_exception), .resp_ack(resp_ack), .timeout(timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count start pulses and watchdog pulses over the whole run.
  always @(posedge clock) begin
    if (!reset) begin
      if (ctrl_MULT) mul_cnt++;
      if (ctrl_DIV)  div_cnt++;
      if (ctrl_MULT && ctrl_DIV) both_cnt++;
      if (timeout)   to_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_units();
    mult_ready = 0; div_ready = 0; mult_exception = 0; div_exception = 0;
    mult_result = 0; div_result = 0;
  endtask

  // Accept a request and check the START cycle; ends at the START negedge.
  task automatic accept(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    #1;
    chk("acc_ready", req_ready, 1);
    chk("acc_stall", stall, 1);
    @(negedge clock);
    req_valid = 0; req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
    chk("st_mult", ctrl_MULT, op == 1'b0);
    chk("st_div",  ctrl_DIV,  op == 1'b1);
    chk("st_a", unit_a, a);
    chk("st_b", unit_b, b);
    chk("st_rdy", req_ready, 0);
  endtask

  // Check the held response against the scoreboard, hold, then acknowledge.
  task automatic finish_resp(input int hold);
    exp_t e;
    logic [31:0] d0;
    chk("done_valid", resp_valid, 1);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("resp_data", resp_data, e.data);
      chk("resp_rd", 32'(resp_rd), 32'(e.rd));
      chk("resp_exc", resp_exception, e.exc);
    end
    d0 = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, d0);
      chk("hold_stall", stall, 1);
    end
    resp_ack = 1;
    @(negedge clock);
    resp_ack = 0;
    chk("ack_valid", resp_valid, 0);
    chk("ack_stall", stall, 0);
    chk("ack_ready", req_ready, 1);
  endtask

  // Full operation: unit responds in BUSY cycle `lat`; the other unit
  // raises a garbage ready while waiting, which must be ignored.
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input logic [31:0] res,
                       input logic exc, input logic [31:0] e_data, input logic [4:0] e_rd,
                       input logic e_exc, input int hold);
    exp_t e;
    e.data = e_data; e.rd = e_rd; e.exc = e_exc;
    exp_q.push_back(e);
    accept(op, a, b, rd);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clock);
      chk("busy_valid", resp_valid, 0);
      chk("busy_stall", stall, 1);
      if (i == lat) begin
        if (op) begin div_ready = 1; div_result = res; div_exception = exc;
                      mult_ready = 0; mult_exception = 0; end
        else    begin mult_ready = 1; mult_result = res; mult_exception = exc;
                      div_ready = 0; div_exception = 0; end
      end else begin
        if (op) begin mult_ready = 1; mult_result = 32'hDEADBEEF; mult_exception = 1; end
        else    begin div_ready = 1;  div_result = 32'hDEADBEEF;  div_exception = 1; end
      end
    end
    @(negedge clock);
    clr_units();
    finish_resp(hold);
  endtask

  initial begin
    int seen;
    reset = 1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_rd = 0;
    flush = 0; resp_ack = 0;
    clr_units();
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_pulse", {30'd0, ctrl_MULT, ctrl_DIV}, 0);
    chk("rst_a", unit_a, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_to", timeout, 0);

    // mul 7*6, ready 33 cycles after the pulse
    do_op(1'b0, 32'd7, 32'd6, 5'd5, 33, 32'd42, 1'b0, 32'd42, 5'd5, 1'b0, 0);
    // div by zero
    do_op(1'b1, 32'd100, 32'd0, 5'd9, 4, 32'd0, 1'b1, 32'd5, 5'd30, 1'b1, 0);
    // mul overflow
    do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd3, 2, 32'h80000000, 1'b1,
          32'd4, 5'd30, 1'b1, 0);
    // stale mult_ready held from before accept; value sampled in BUSY only
    mult_ready = 1; mult_result = 32'd111;
    do_op(1'b0, 32'd5, 32'd5, 5'd0, 1, 32'd25, 1'b0, 32'd25, 5'd0, 1'b0, 0);

    // flush 10 cycles into a div, with a same-cycle div_ready
    accept(1'b1, 32'd100, 32'd7, 5'd8);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 10) begin flush = 1; div_ready = 1; div_result = 32'd14; end
    end
    @(negedge clock);
    flush = 0;
    clr_units();
    chk("fl_ready", req_ready, 1);
    chk("fl_valid", resp_valid, 0);
    chk("fl_stall", stall, 0);
    repeat (3) @(negedge clock);
    chk("fl_valid2", resp_valid, 0);
    do_op(1'b0, 32'd3, 32'd3, 5'd7, 6, 32'd9, 1'b0, 32'd9, 5'd7, 1'b0, 0);

    // flush in IDLE blocks a same-cycle request
    flush = 1; req_valid = 1; req_op = 0;
    @(negedge clock);
    flush = 0; req_valid = 0;
    chk("fi_ready", req_ready, 1);
    chk("fi_mult", ctrl_MULT, 0);

    // watchdog: unit never readies; ack held off for 5 cycles
    begin
      exp_t e;
      e.data = 32'd4; e.rd = 5'd30; e.exc = 1'b1;
      exp_q.push_back(e);
    end
    accept(1'b0, 32'd1, 32'd2, 5'd11);
    seen = 0;
    for (int i = 1; i <= 60 && seen == 0; i++) begin
      @(negedge clock);
      if (timeout) seen = i;
      else chk("to_valid", resp_valid, 0);
    end
    chk("to_cycle", seen, 40);
    @(negedge clock);
    chk("to_pulse_off", timeout, 0);
    finish_resp(5);

    @(negedge clock);
    @(negedge clock);
    chk("mul_pulses", mul_cnt, 5);
    chk("div_pulses", div_cnt, 2);
    chk("both_pulses", both_cnt, 0);
    chk("to_pulses", to_cnt, 1);
    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
